// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multi-cycle RV32I control FSM with an optional MUL handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int unsigned ALU_FUNC_W  = 3,
    parameter int unsigned ENABLE_MUL  = 1,
    parameter int unsigned MUL_TIMEOUT = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opc,
    input  logic [2:0]            f3,
    input  logic [6:0]            f7,
    input  logic                  zero,
    input  logic                  neg,
    input  logic                  mul_done,
    output logic                  PC_write,
    output logic                  adr_src,
    output logic                  IR_write,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic [1:0]            ALU_src_A,
    output logic [1:0]            ALU_src_B,
    output logic [1:0]            result_src,
    output logic                  mul_sel,
    output logic [2:0]            imm_src,
    output logic [ALU_FUNC_W-1:0] ALU_func,
    output logic                  mul_start,
    output logic                  illegal
);

    localparam int unsigned CNT_W = $clog2(MUL_TIMEOUT + 1);

    localparam logic [6:0] c_OPC_R    = 7'b0110011;
    localparam logic [6:0] c_OPC_I    = 7'b0010011;
    localparam logic [6:0] c_OPC_LW   = 7'b0000011;
    localparam logic [6:0] c_OPC_SW   = 7'b0100011;
    localparam logic [6:0] c_OPC_BR   = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL  = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR = 7'b1100111;
    localparam logic [6:0] c_OPC_LUI  = 7'b0110111;
    localparam logic [6:0] c_F7_MUL   = 7'b0000001;

    localparam logic [ALU_FUNC_W-1:0] c_ADD  = ALU_FUNC_W'(0);
    localparam logic [ALU_FUNC_W-1:0] c_SUB  = ALU_FUNC_W'(1);
    localparam logic [ALU_FUNC_W-1:0] c_AND  = ALU_FUNC_W'(2);
    localparam logic [ALU_FUNC_W-1:0] c_OR   = ALU_FUNC_W'(3);
    localparam logic [ALU_FUNC_W-1:0] c_SLT  = ALU_FUNC_W'(4);
    localparam logic [ALU_FUNC_W-1:0] c_XOR  = ALU_FUNC_W'(5);
    localparam logic [ALU_FUNC_W-1:0] c_SLTU = ALU_FUNC_W'(6);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MUL_TIMEOUT - 1);

    typedef enum logic [4:0] {
        S_FETCH    = 5'd0,
        S_DECODE   = 5'd1,
        S_EXEC_R   = 5'd2,
        S_EXEC_I   = 5'd3,
        S_ALU_WB   = 5'd4,
        S_MEM_ADR  = 5'd5,
        S_MEM_RD   = 5'd6,
        S_MEM_WB   = 5'd7,
        S_MEM_WR   = 5'd8,
        S_BRANCH   = 5'd9,
        S_JAL      = 5'd10,
        S_JALR_A   = 5'd11,
        S_JALR_B   = 5'd12,
        S_LUI      = 5'd13,
        S_MUL_WAIT = 5'd14,
        S_MUL_WB   = 5'd15,
        S_TRAP     = 5'd16
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [CNT_W-1:0]        r_mul_cnt;
    logic [ALU_FUNC_W-1:0]   w_alu_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Counts cycles spent in MUL_WAIT; zero marks the entry (start pulse) cycle.
    always_ff @(posedge clk) begin
        if (rst || (r_state != S_MUL_WAIT)) begin
            r_mul_cnt <= '0;
        end else begin
            r_mul_cnt <= r_mul_cnt + 1'b1;
        end
    end

    // Shift funct3 codes have no ALU encoding here and fall back to add.
    always_comb begin
        w_alu_op = c_ADD;
        case (f3)
            3'b000:  w_alu_op = ((r_state == S_EXEC_R) && f7[5]) ? c_SUB : c_ADD;
            3'b010:  w_alu_op = c_SLT;
            3'b011:  w_alu_op = c_SLTU;
            3'b100:  w_alu_op = c_XOR;
            3'b110:  w_alu_op = c_OR;
            3'b111:  w_alu_op = c_AND;
            default: w_alu_op = c_ADD;
        endcase
    end

    always_comb begin
        imm_src = 3'd0;
        case (opc)
            c_OPC_SW:  imm_src = 3'd1;
            c_OPC_BR:  imm_src = 3'd2;
            c_OPC_JAL: imm_src = 3'd3;
            c_OPC_LUI: imm_src = 3'd4;
            default:   imm_src = 3'd0;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        PC_write   = 1'b0;
        adr_src    = 1'b0;
        IR_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        ALU_src_A  = 2'b00;
        ALU_src_B  = 2'b00;
        result_src = 2'b00;
        mul_sel    = 1'b0;
        ALU_func   = c_ADD;
        mul_start  = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                IR_write   = 1'b1;
                ALU_src_B  = 2'b10;
                result_src = 2'b10;
                PC_write   = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                ALU_src_A = 2'b01;
                ALU_src_B = 2'b01;
                case (opc)
                    c_OPC_R: begin
                        if (f7 == c_F7_MUL) begin
                            w_next = ((ENABLE_MUL != 0) && (f3 == 3'b000)) ? S_MUL_WAIT : S_TRAP;
                        end else begin
                            w_next = S_EXEC_R;
                        end
                    end
                    c_OPC_I:    w_next = S_EXEC_I;
                    c_OPC_LW:   w_next = S_MEM_ADR;
                    c_OPC_SW:   w_next = S_MEM_ADR;
                    c_OPC_BR:   w_next = S_BRANCH;
                    c_OPC_JAL:  w_next = S_JAL;
                    c_OPC_JALR: w_next = S_JALR_A;
                    c_OPC_LUI:  w_next = S_LUI;
                    default:    w_next = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                ALU_src_A = 2'b10;
                ALU_func  = w_alu_op;
                w_next    = S_ALU_WB;
            end
            S_EXEC_I: begin
                ALU_src_A = 2'b10;
                ALU_src_B = 2'b01;
                ALU_func  = w_alu_op;
                w_next    = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEM_ADR: begin
                ALU_src_A = 2'b10;
                ALU_src_B = 2'b01;
                w_next    = (opc == c_OPC_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                adr_src = 1'b1;
                w_next  = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                ALU_src_A = 2'b10;
                ALU_func  = c_SUB;
                w_next    = S_FETCH;
                case (f3)
                    3'b000:  PC_write = zero;
                    3'b001:  PC_write = ~zero;
                    3'b100:  PC_write = neg;
                    3'b101:  PC_write = ~neg;
                    default: w_next   = S_TRAP;
                endcase
            end
            S_JAL, S_JALR_B: begin
                PC_write  = 1'b1;
                ALU_src_A = 2'b01;
                ALU_src_B = 2'b10;
                w_next    = S_ALU_WB;
            end
            S_JALR_A: begin
                ALU_src_A = 2'b10;
                ALU_src_B = 2'b01;
                w_next    = S_JALR_B;
            end
            S_LUI: begin
                result_src = 2'b11;
                reg_write  = 1'b1;
                w_next     = S_FETCH;
            end
            S_MUL_WAIT: begin
                mul_start = (r_mul_cnt == '0);
                if (mul_done) begin
                    w_next = S_MUL_WB;
                end else if (r_mul_cnt == c_CNT_LAST) begin
                    w_next = S_TRAP;
                end
            end
            S_MUL_WB: begin
                mul_sel   = 1'b1;
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
        // Reset aborts the current instruction: suppress every side effect.
        if (rst) begin
            PC_write  = 1'b0;
            IR_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            mul_start = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed, table-driven bench for multicycle_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       zero, neg, mul_done;
    logic       PC_write, adr_src, IR_write, mem_write, reg_write, mul_sel, mul_start, illegal;
    logic [1:0] ALU_src_A, ALU_src_B, result_src;
    logic [2:0] imm_src;
    logic [2:0] ALU_func;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] c_R    = 7'b0110011;
    localparam logic [6:0] c_I    = 7'b0010011;
    localparam logic [6:0] c_LW   = 7'b0000011;
    localparam logic [6:0] c_SW   = 7'b0100011;
    localparam logic [6:0] c_BR   = 7'b1100011;
    localparam logic [6:0] c_JAL  = 7'b1101111;
    localparam logic [6:0] c_JALR = 7'b1100111;
    localparam logic [6:0] c_LUI  = 7'b0110111;
    localparam logic [6:0] c_F7S  = 7'b0100000;
    localparam logic [6:0] c_F7M  = 7'b0000001;

    multicycle_controller #(
        .ALU_FUNC_W (3),
        .ENABLE_MUL (1),
        .MUL_TIMEOUT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opc       (opc),
        .f3        (f3),
        .f7        (f7),
        .zero      (zero),
        .neg       (neg),
        .mul_done  (mul_done),
        .PC_write  (PC_write),
        .adr_src   (adr_src),
        .IR_write  (IR_write),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .ALU_src_A (ALU_src_A),
        .ALU_src_B (ALU_src_B),
        .result_src(result_src),
        .mul_sel   (mul_sel),
        .imm_src   (imm_src),
        .ALU_func  (ALU_func),
        .mul_start (mul_start),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // {PC_write, adr_src, IR_write, mem_write, reg_write, A, B, result_src, mul_sel, imm_src, ALU_func, mul_start, illegal}
    logic [19:0] w_got;
    assign w_got = {PC_write, adr_src, IR_write, mem_write, reg_write, ALU_src_A, ALU_src_B,
                    result_src, mul_sel, imm_src, ALU_func, mul_start, illegal};

    typedef struct {
        logic        rst;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        zero;
        logic        neg;
        logic        mul_done;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [19:0] ex(input logic pcw, input logic adr, input logic irw,
                                       input logic mw, input logic rw, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] rs, input logic ms,
                                       input logic [2:0] imm, input logic [2:0] fn,
                                       input logic st, input logic ill);
        return {pcw, adr, irw, mw, rw, a, b, rs, ms, imm, fn, st, ill};
    endfunction

    function automatic logic [19:0] e_fetch(input logic [2:0] imm);
        return ex(1, 0, 1, 0, 0, 2'b00, 2'b10, 2'b10, 0, imm, 3'd0, 0, 0);
    endfunction
    function automatic logic [19:0] e_dec(input logic [2:0] imm);
        return ex(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 0, imm, 3'd0, 0, 0);
    endfunction
    function automatic logic [19:0] e_wb(input logic [2:0] imm);
        return ex(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, imm, 3'd0, 0, 0);
    endfunction
    function automatic logic [19:0] e_idle(input logic [2:0] imm);
        return ex(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, imm, 3'd0, 0, 0);
    endfunction
    function automatic logic [19:0] e_trap(input logic [2:0] imm);
        return ex(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, imm, 3'd0, 0, 1);
    endfunction

    task automatic add_vec(input logic r, input logic [6:0] o, input logic [2:0] f3v,
                           input logic [6:0] f7v, input logic z, input logic n,
                           input logic md, input logic [19:0] e);
        vec_t v;
        v.rst = r; v.opc = o; v.f3 = f3v; v.f7 = f7v;
        v.zero = z; v.neg = n; v.mul_done = md; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [19:0] exp);
        checks++;
        if (w_got !== exp) begin
            failures++;
            $display("FAIL %s got=%05h exp=%05h", name, w_got, exp);
        end
    endtask

    // Runs one instruction from FETCH and counts cycles until the next FETCH.
    task automatic count_cycles(input string name, input logic [6:0] o, input logic [2:0] f3v,
                                input logic [6:0] f7v, input logic md, input int exp_n);
        int n = 0;
        rst = 0; opc = o; f3 = f3v; f7 = f7v; zero = 0; neg = 0; mul_done = md;
        #1;
        checks++;
        if (IR_write !== 1'b1) begin
            failures++;
            $display("FAIL %s_start IR_write got=%b exp=1", name, IR_write);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n++;
            if (IR_write === 1'b1) break;
        end
        checks++;
        if (n != exp_n) begin
            failures++;
            $display("FAIL %s cycles got=%0d exp=%0d", name, n, exp_n);
        end
    endtask

    initial begin
        rst = 1; opc = c_LUI; f3 = 0; f7 = 0; zero = 0; neg = 0; mul_done = 0;

        // add x3,x1,x2
        add_vec(0, c_R, 3'b000, 7'd0, 0, 0, 0, e_fetch(0));
        add_vec(0, c_R, 3'b000, 7'd0, 0, 0, 0, e_dec(0));
        add_vec(0, c_R, 3'b000, 7'd0, 0, 0, 0, ex(0,0,0,0,0,2'b10,2'b00,2'b00,0,0,3'd0,0,0));
        add_vec(0, c_R, 3'b000, 7'd0, 0, 0, 0, e_wb(0));
        // sub
        add_vec(0, c_R, 3'b000, c_F7S, 0, 0, 0, e_fetch(0));
        add_vec(0, c_R, 3'b000, c_F7S, 0, 0, 0, e_dec(0));
        add_vec(0, c_R, 3'b000, c_F7S, 0, 0, 0, ex(0,0,0,0,0,2'b10,2'b00,2'b00,0,0,3'd1,0,0));
        add_vec(0, c_R, 3'b000, c_F7S, 0, 0, 0, e_wb(0));
        // xori (f7[5] set must not turn I-type into anything but xor)
        add_vec(0, c_I, 3'b100, c_F7S, 0, 0, 0, e_fetch(0));
        add_vec(0, c_I, 3'b100, c_F7S, 0, 0, 0, e_dec(0));
        add_vec(0, c_I, 3'b100, c_F7S, 0, 0, 0, ex(0,0,0,0,0,2'b10,2'b01,2'b00,0,0,3'd5,0,0));
        add_vec(0, c_I, 3'b100, c_F7S, 0, 0, 0, e_wb(0));
        // lw
        add_vec(0, c_LW, 3'b010, 7'd0, 0, 0, 0, e_fetch(0));
        add_vec(0, c_LW, 3'b010, 7'd0, 0, 0, 0, e_dec(0));
        add_vec(0, c_LW, 3'b010, 7'd0, 0, 0, 0, ex(0,0,0,0,0,2'b10,2'b01,2'b00,0,0,3'd0,0,0));
        add_vec(0, c_LW, 3'b010, 7'd0, 0, 0, 0, ex(0,1,0,0,0,2'b00,2'b00,2'b00,0,0,3'd0,0,0));
        add_vec(0, c_LW, 3'b010, 7'd0, 0, 0, 0, ex(0,1,0,0,1,2'b00,2'b00,2'b01,0,0,3'd0,0,0) & ~20'h40000);
        // sw aborted by reset in MEM_WR, then a complete sw
        add_vec(0, c_SW, 3'b010, 7'd0, 0, 0, 0, e_fetch(1));
        add_vec(0, c_SW, 3'b010, 7'd0, 0, 0, 0, e_dec(1));
        add_vec(0, c_SW, 3'b010, 7'd0, 0, 0, 0, ex(0,0,0,0,0,2'b10,2'b01,2'b00,0,1,3'd0,0,0));
        add_vec(1, c_SW, 3'b010, 7'd0, 0, 0, 0, ex(0,1,0,0,0,2'b00,2'b00,2'b00,0,1,3'd0,0,0));
        add_vec(0, c_SW, 3'b010, 7'd0, 0, 0, 0, e_fetch(1));
        add_vec(0, c_SW, 3'b010, 7'd0, 0, 0, 0, e_dec(1));
        add_vec(0, c_SW, 3'b010, 7'd0, 0, 0, 0, ex(0,0,0,0,0,2'b10,2'b01,2'b00,0,1,3'd0,0,0));
        add_vec(0, c_SW, 3'b010, 7'd0, 0, 0, 0, ex(0,1,0,1,0,2'b00,2'b00,2'b00,0,1,3'd0,0,0));
        // beq taken / not taken, bge with neg=0
        add_vec(0, c_BR, 3'b000, 7'd0, 1, 0, 0, e_fetch(2));
        add_vec(0, c_BR, 3'b000, 7'd0, 1, 0, 0, e_dec(2));
        add_vec(0, c_BR, 3'b000, 7'd0, 1, 0, 0, ex(1,0,0,0,0,2'b10,2'b00,2'b00,0,2,3'd1,0,0));
        add_vec(0, c_BR, 3'b000, 7'd0, 0, 0, 0, e_fetch(2));
        add_vec(0, c_BR, 3'b000, 7'd0, 0, 0, 0, e_dec(2));
        add_vec(0, c_BR, 3'b000, 7'd0, 0, 0, 0, ex(0,0,0,0,0,2'b10,2'b00,2'b00,0,2,3'd1,0,0));
        add_vec(0, c_BR, 3'b101, 7'd0, 0, 0, 0, e_fetch(2));
        add_vec(0, c_BR, 3'b101, 7'd0, 0, 0, 0, e_dec(2));
        add_vec(0, c_BR, 3'b101, 7'd0, 0, 0, 0, ex(1,0,0,0,0,2'b10,2'b00,2'b00,0,2,3'd1,0,0));
        // jal
        add_vec(0, c_JAL, 3'b000, 7'd0, 0, 0, 0, e_fetch(3));
        add_vec(0, c_JAL, 3'b000, 7'd0, 0, 0, 0, e_dec(3));
        add_vec(0, c_JAL, 3'b000, 7'd0, 0, 0, 0, ex(1,0,0,0,0,2'b01,2'b10,2'b00,0,3,3'd0,0,0));
        add_vec(0, c_JAL, 3'b000, 7'd0, 0, 0, 0, e_wb(3));
        // jalr
        add_vec(0, c_JALR, 3'b000, 7'd0, 0, 0, 0, e_fetch(0));
        add_vec(0, c_JALR, 3'b000, 7'd0, 0, 0, 0, e_dec(0));
        add_vec(0, c_JALR, 3'b000, 7'd0, 0, 0, 0, ex(0,0,0,0,0,2'b10,2'b01,2'b00,0,0,3'd0,0,0));
        add_vec(0, c_JALR, 3'b000, 7'd0, 0, 0, 0, ex(1,0,0,0,0,2'b01,2'b10,2'b00,0,0,3'd0,0,0));
        add_vec(0, c_JALR, 3'b000, 7'd0, 0, 0, 0, e_wb(0));
        // lui
        add_vec(0, c_LUI, 3'b000, 7'd0, 0, 0, 0, e_fetch(4));
        add_vec(0, c_LUI, 3'b000, 7'd0, 0, 0, 0, e_dec(4));
        add_vec(0, c_LUI, 3'b000, 7'd0, 0, 0, 0, ex(0,0,0,0,1,2'b00,2'b00,2'b11,0,4,3'd0,0,0));
        // mul with mul_done on the third wait cycle
        add_vec(0, c_R, 3'b000, c_F7M, 0, 0, 0, e_fetch(0));
        add_vec(0, c_R, 3'b000, c_F7M, 0, 0, 0, e_dec(0));
        add_vec(0, c_R, 3'b000, c_F7M, 0, 0, 0, ex(0,0,0,0,0,2'b00,2'b00,2'b00,0,0,3'd0,1,0));
        add_vec(0, c_R, 3'b000, c_F7M, 0, 0, 0, e_idle(0));
        add_vec(0, c_R, 3'b000, c_F7M, 0, 0, 1, e_idle(0));
        add_vec(0, c_R, 3'b000, c_F7M, 0, 0, 0, ex(0,0,0,0,1,2'b00,2'b00,2'b00,1,0,3'd0,0,0));
        // beq with f3=010 traps; reset clears illegal
        add_vec(0, c_BR, 3'b010, 7'd0, 1, 0, 0, e_fetch(2));
        add_vec(0, c_BR, 3'b010, 7'd0, 1, 0, 0, e_dec(2));
        add_vec(0, c_BR, 3'b010, 7'd0, 1, 0, 0, ex(0,0,0,0,0,2'b10,2'b00,2'b00,0,2,3'd1,0,0));
        add_vec(0, c_BR, 3'b010, 7'd0, 1, 0, 0, e_trap(2));
        add_vec(0, c_BR, 3'b010, 7'd0, 1, 0, 0, e_trap(2));
        add_vec(1, c_BR, 3'b010, 7'd0, 1, 0, 0, e_idle(2));
        // mul timeout after 4 wait cycles
        add_vec(0, c_R, 3'b000, c_F7M, 0, 0, 0, e_fetch(0));
        add_vec(0, c_R, 3'b000, c_F7M, 0, 0, 0, e_dec(0));
        add_vec(0, c_R, 3'b000, c_F7M, 0, 0, 0, ex(0,0,0,0,0,2'b00,2'b00,2'b00,0,0,3'd0,1,0));
        add_vec(0, c_R, 3'b000, c_F7M, 0, 0, 0, e_idle(0));
        add_vec(0, c_R, 3'b000, c_F7M, 0, 0, 0, e_idle(0));
        add_vec(0, c_R, 3'b000, c_F7M, 0, 0, 0, e_idle(0));
        add_vec(0, c_R, 3'b000, c_F7M, 0, 0, 0, e_trap(0));
        add_vec(1, c_R, 3'b000, c_F7M, 0, 0, 0, e_idle(0));
        // undefined opcode
        add_vec(0, 7'd0, 3'b000, 7'd0, 0, 0, 0, e_fetch(0));
        add_vec(0, 7'd0, 3'b000, 7'd0, 0, 0, 0, e_dec(0));
        add_vec(0, 7'd0, 3'b000, 7'd0, 0, 0, 0, e_trap(0));
        add_vec(1, 7'd0, 3'b000, 7'd0, 0, 0, 0, e_idle(0));

        // Reset state: FETCH datapath selects with every write strobe suppressed.
        repeat (2) @(posedge clk);
        #1;
        check("reset_fetch", ex(0,0,0,0,0,2'b00,2'b10,2'b10,0,4,3'd0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; opc = vecs[i].opc; f3 = vecs[i].f3; f7 = vecs[i].f7;
            zero = vecs[i].zero; neg = vecs[i].neg; mul_done = vecs[i].mul_done;
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
            @(posedge clk); #1;
        end

        count_cycles("lui_len", c_LUI, 3'b000, 7'd0, 0, 3);
        count_cycles("lw_len", c_LW, 3'b010, 7'd0, 0, 5);
        count_cycles("jalr_len", c_JALR, 3'b000, 7'd0, 0, 5);
        count_cycles("mul_k0_len", c_R, 3'b000, c_F7M, 1, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
